// File: rtl/cond_accum_fsmd.sv
// cond_accum_fsmd
//
// Conditional accumulator FSMD. A start (from IDLE or DONE) clears the
// datapath and enters a CHECK/ACC loop that runs while `cont` is high and
// the iteration limit has not been hit. Each ACC pass optionally adds or
// subtracts `inputA`, with either wrap-around or saturating arithmetic and
// a sticky overflow flag.
//
// Parameters:
//   W      accumulator / operand width
//   CNT_W  iteration counter width
//   SAT    0 = wrap-around, 1 = saturate at 0 and 2^W-1
//
// Ports:
//   clock     in   posedge clock
//   reset_L   in   asynchronous active-low reset
//   start     in   begin/restart a run (IDLE and DONE only)
//   cont      in   loop-continue condition (CHECK)
//   take      in   accumulate enable (ACC)
//   sub       in   0 = add, 1 = subtract (ACC)
//   inputA    in   unsigned operand (ACC)
//   maxIter   in   iteration limit, 0 = unlimited (CHECK)
//   value     out  accumulator
//   count     out  completed ACC passes
//   busy      out  high in CHECK or ACC
//   done      out  high in DONE
//   overflow  out  sticky overflow/underflow flag
module cond_accum_fsmd #(
    parameter int W     = 8,
    parameter int CNT_W = 4,
    parameter int SAT   = 0
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             start,
    input  logic             cont,
    input  logic             take,
    input  logic             sub,
    input  logic [W-1:0]     inputA,
    input  logic [CNT_W-1:0] maxIter,
    output logic [W-1:0]     value,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ACC   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;

    // Returns {carry, result}; on carry the result is clamped when saturating.
    function automatic logic [W:0] add_op(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[W] && (SAT != 0))
            s[W-1:0] = '1;
        return s;
    endfunction

    // Returns {borrow, result}; on borrow the result is clamped when saturating.
    function automatic logic [W:0] sub_op(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[W] && (SAT != 0))
            d[W-1:0] = '0;
        return d;
    endfunction

    logic [W:0] acc_res;
    logic       loop_ok;

    always_comb begin
        acc_res = sub ? sub_op(value, inputA) : add_op(value, inputA);
    end

    // Limit check: 0 means unlimited, otherwise stop once count reaches it.
    always_comb begin
        loop_ok = cont && ((maxIter == '0) || (count != maxIter));
    end

    // busy/done are registered alongside the state so they carry no
    // combinational path from inputs.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state    <= IDLE;
            value    <= '0;
            count    <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= CHECK;
                        value    <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                CHECK: begin
                    if (loop_ok) begin
                        state <= ACC;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ACC: begin
                    state <= CHECK;
                    count <= count + CNT_W'(1);
                    if (take) begin
                        value <= acc_res[W-1:0];
                        if (acc_res[W])
                            overflow <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cond_accum_fsmd.sv
module tb_cond_accum_fsmd;

    logic       clock = 1'b0;
    logic       reset_L = 1'b0;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       take = 1'b0;
    logic       sub = 1'b0;
    logic [7:0] inputA = 8'd0;
    logic [3:0] maxIter = 4'd0;

    logic [7:0] v0, v1;
    logic [3:0] c0, c1;
    logic       b0, b1, d0, d1, o0, o1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int v;
        int c;
        int o;
        int len;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    cond_accum_fsmd #(.W(8), .CNT_W(4), .SAT(0)) dut0 (
        .clock(clock), .reset_L(reset_L), .start(start), .cont(cont),
        .take(take), .sub(sub), .inputA(inputA), .maxIter(maxIter),
        .value(v0), .count(c0), .busy(b0), .done(d0), .overflow(o0)
    );

    cond_accum_fsmd #(.W(8), .CNT_W(4), .SAT(1)) dut1 (
        .clock(clock), .reset_L(reset_L), .start(start), .cont(cont),
        .take(take), .sub(sub), .inputA(inputA), .maxIter(maxIter),
        .value(v1), .count(c1), .busy(b1), .done(d1), .overflow(o1)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int v, input int c, input int o, input int len);
        exp_t e;
        e.v = v; e.c = c; e.o = o; e.len = len;
        return e;
    endfunction

    // Monitor: sample on the falling edge, pop an expectation whenever a
    // DUT enters DONE, and measure run length from the first busy cycle.
    logic pd0 = 1'b0, pd1 = 1'b0, pb0 = 1'b0, pb1 = 1'b0;
    int   s0 = 0, s1 = 0;

    always @(negedge clock) begin
        exp_t e;
        cyc++;
        if (b0 && !pb0) s0 = cyc;
        if (b1 && !pb1) s1 = cyc;
        if (d0 && !pd0) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL sat0_unexpected_done: got done=1, expected no run pending");
            end else begin
                e = q0.pop_front();
                chk("sat0_value", 32'(v0), 32'(e.v));
                chk("sat0_count", 32'(c0), 32'(e.c));
                chk("sat0_overflow", 32'(o0), 32'(e.o));
                chk("sat0_runlen", 32'(cyc - s0), 32'(e.len));
            end
        end
        if (d1 && !pd1) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL sat1_unexpected_done: got done=1, expected no run pending");
            end else begin
                e = q1.pop_front();
                chk("sat1_value", 32'(v1), 32'(e.v));
                chk("sat1_count", 32'(c1), 32'(e.c));
                chk("sat1_overflow", 32'(o1), 32'(e.o));
                chk("sat1_runlen", 32'(cyc - s1), 32'(e.len));
            end
        end
        pd0 = d0; pd1 = d1; pb0 = b0; pb1 = b1;
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_value0"}, 32'(v0), 0);
        chk({tag, "_count0"}, 32'(c0), 0);
        chk({tag, "_ovf0"},   32'(o0), 0);
        chk({tag, "_busy0"},  32'(b0), 0);
        chk({tag, "_done0"},  32'(d0), 0);
        chk({tag, "_value1"}, 32'(v1), 0);
        chk({tag, "_count1"}, 32'(c1), 0);
        chk({tag, "_ovf1"},   32'(o1), 0);
        chk({tag, "_busy1"},  32'(b1), 0);
        chk({tag, "_done1"},  32'(d1), 0);
    endtask

    // One run: start, n loop passes with per-pass operands, then exit either
    // by cont=0 or (hold_cont=1) by the iteration limit. pulse_iter selects
    // an ACC cycle in which start is pulsed (-1 = none).
    task automatic do_run(input int n, input logic [63:0] a_vec,
                          input logic [7:0] take_vec, input logic [7:0] sub_vec,
                          input logic [3:0] mi, input logic hold_cont,
                          input int pulse_iter, input logic chk_clear,
                          input exp_t e0, input exp_t e1);
        bit got;
        q0.push_back(e0);
        q1.push_back(e1);
        maxIter = mi;
        cont = 1'b0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        if (chk_clear) begin
            chk("restart_value0", 32'(v0), 0);
            chk("restart_count0", 32'(c0), 0);
            chk("restart_ovf0",   32'(o0), 0);
            chk("restart_busy0",  32'(b0), 1);
            chk("restart_value1", 32'(v1), 0);
            chk("restart_ovf1",   32'(o1), 0);
        end
        for (int i = 0; i < n; i++) begin
            cont   = 1'b1;
            take   = take_vec[i];
            sub    = sub_vec[i];
            inputA = a_vec[i*8 +: 8];
            @(posedge clock); #1;
            if (i == pulse_iter) start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
        end
        cont = hold_cont;
        got = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (d0 && d1) begin
                got = 1'b1;
                break;
            end
            @(posedge clock); #1;
        end
        if (!got) chk("done_timeout", 0, 1);
        @(posedge clock); #1;
    endtask

    initial begin
        // Reset state
        #3;
        check_all_zero("reset");
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_L = 1'b1;
        @(posedge clock); #1;

        // Basic add: 3 x 7
        do_run(3, {40'd0, 8'd7, 8'd7, 8'd7}, 8'b0000_0111, 8'b0, 4'd0, 1'b0, -1, 1'b0,
               mk(21, 3, 0, 7), mk(21, 3, 0, 7));

        // Iteration limit 4 with cont held high, take alternating
        do_run(4, {32'd0, 8'd10, 8'd10, 8'd10, 8'd10}, 8'b0000_0101, 8'b0, 4'd4, 1'b1, -1, 1'b0,
               mk(20, 4, 0, 9), mk(20, 4, 0, 9));

        // 200 + 100: wraps to 44 / saturates to 255
        do_run(2, {48'd0, 8'd100, 8'd200}, 8'b0000_0011, 8'b0, 4'd0, 1'b0, -1, 1'b0,
               mk(44, 2, 1, 5), mk(255, 2, 1, 5));

        // 3 - 5: wraps to 254 / saturates to 0
        do_run(2, {48'd0, 8'd5, 8'd3}, 8'b0000_0011, 8'b0000_0010, 4'd0, 1'b0, -1, 1'b0,
               mk(254, 2, 1, 5), mk(0, 2, 1, 5));

        // Restart from DONE (clears checked), start pulsed during first ACC
        do_run(2, {48'd0, 8'd2, 8'd1}, 8'b0000_0011, 8'b0, 4'd0, 1'b0, 0, 1'b1,
               mk(3, 2, 0, 5), mk(3, 2, 0, 5));

        // Immediate exit with cont=0
        do_run(0, 64'd0, 8'b0, 8'b0, 4'd0, 1'b0, -1, 1'b0,
               mk(0, 0, 0, 1), mk(0, 0, 0, 1));

        // Reset mid-run during the second ACC
        maxIter = 4'd0;
        cont = 1'b1; take = 1'b1; sub = 1'b0; inputA = 8'd5;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("midrun_value_before", 32'(v0), 5);
        @(posedge clock); #1;
        reset_L = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        @(posedge clock); #1;
        reset_L = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
        end
        check_all_zero("post_reset_idle");

        chk("queues_drained", 32'(q0.size() + q1.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
